// File: rtl/fp_normalizer_seq_if.sv
// Handshake bundle for the sequential FP normaliser: operand in, packed result plus flags out.
interface fp_normalizer_seq_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W-1:0]       in_exp;
  logic [MAN_W+1:0]       in_man;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_result;
  logic                   out_zero;
  logic                   out_ovf;
  logic                   out_unf;

  modport master (
    output in_valid, in_sign, in_exp, in_man, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_man, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/fp_normalizer_seq.sv
// Multi-cycle post-add/sub normaliser: one right shift on carry, else one left shift per cycle
// until the hidden bit is set; flags zero, overflow and underflow.
module fp_normalizer_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic                clk,
  input logic                rst_n,
  fp_normalizer_seq_if.slave bus
);

  localparam int unsigned RES_W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q;
  logic               sign_q;
  logic [EXP_W:0]     exp_q;
  logic [MAN_W+1:0]   man_q;
  logic [RES_W-1:0]   result_q;
  logic               zero_q;
  logic               ovf_q;
  logic               unf_q;
  logic               valid_q;
  logic               ready_q;

  logic [EXP_W:0]     exp_inc_d;
  logic [EXP_W:0]     exp_dec_d;
  logic [MAN_W-1:0]   frac_shr_d;

  // Exponent kept one bit wider so increment/decrement can never wrap.
  always_comb begin
    exp_inc_d  = exp_q + EXP_ONE;
    exp_dec_d  = exp_q - EXP_ONE;
    frac_shr_d = man_q[MAN_W:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      man_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q  <= bus.in_sign;
            exp_q   <= {1'b0, bus.in_exp};
            man_q   <= bus.in_man;
            ready_q <= 1'b0;
            if (&bus.in_exp) begin
              // Inf/NaN bypasses normalisation; fraction passes through untouched.
              result_q <= {bus.in_sign, bus.in_exp, bus.in_man[MAN_W-1:0]};
              valid_q  <= 1'b1;
              state_q  <= HOLD;
            end else begin
              state_q  <= NORM;
            end
          end
        end

        NORM: begin
          if (man_q == '0) begin
            result_q <= {sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            zero_q   <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= HOLD;
          end else if (man_q[MAN_W+1]) begin
            if (exp_inc_d >= EXP_MAX) begin
              result_q <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              ovf_q    <= 1'b1;
            end else begin
              result_q <= {sign_q, exp_inc_d[EXP_W-1:0], frac_shr_d};
            end
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else if (man_q[MAN_W]) begin
            result_q <= {sign_q, exp_q[EXP_W-1:0], man_q[MAN_W-1:0]};
            valid_q  <= 1'b1;
            state_q  <= HOLD;
          end else if (exp_q <= EXP_ONE) begin
            result_q <= {sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            unf_q    <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= HOLD;
          end else begin
            man_q <= {man_q[MAN_W:0], 1'b0};
            exp_q <= exp_dec_d;
          end
        end

        HOLD: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: begin
          valid_q <= 1'b0;
          zero_q  <= 1'b0;
          ovf_q   <= 1'b0;
          unf_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_ovf    = ovf_q;
  assign bus.out_unf    = unf_q;

endmodule

// File: tb/tb_fp_normalizer_seq.sv
// Scoreboard bench for fp_normalizer_seq (EXP_W=8, MAN_W=23).
module tb_fp_normalizer_seq;

  logic clk;
  logic rst_n;

  fp_normalizer_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_normalizer_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [2:0]  flg;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Result transfer happens on the posedge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_result"}, 64'(bus.out_result), 64'(mon_e.res));
        chk({mon_e.tag, "_flags"}, 64'({bus.out_zero, bus.out_ovf, bus.out_unf}), 64'(mon_e.flg));
      end
    end
  end

  // flg = {zero, ovf, unf}; lat = edges from accept to out_valid (0 skips); hold = stall cycles.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m,
                        input logic [31:0] res, input logic [2:0] flg, input int lat, input int hold);
    sb_entry_t ent;
    int n;
    ent.tag = tag;
    ent.res = res;
    ent.flg = flg;
    sb.push_back(ent);
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_man   = m;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 64) begin
      chk({tag, "_busy_in_ready"}, 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.out_valid) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      sb.delete();
      return;
    end
    if (lat != 0) chk({tag, "_latency"}, 64'(n + 1), 64'(lat));
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_result"}, 64'(bus.out_result), 64'(res));
      chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_valid_clear"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_flags_clear"}, 64'({bus.out_zero, bus.out_ovf, bus.out_unf}), 64'd0);
    chk({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_man    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_result", 64'(bus.out_result), 64'd0);
    chk("rst_flags", 64'({bus.out_zero, bus.out_ovf, bus.out_unf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("norm",      1'b0, 8'h80, 25'h0C00000, 32'h40400000, 3'b000, 2, 0);
    run_op("carry",     1'b0, 8'h7F, 25'h1800000, 32'h40400000, 3'b000, 2, 0);
    run_op("lshift3",   1'b0, 8'h82, 25'h0180000, 32'h3FC00000, 3'b000, 5, 4);
    run_op("zero",      1'b1, 8'h55, 25'h0000000, 32'h80000000, 3'b100, 2, 0);
    run_op("ovf",       1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 3'b010, 2, 0);
    run_op("unf",       1'b0, 8'h02, 25'h0200000, 32'h00000000, 3'b001, 3, 0);
    run_op("inf",       1'b0, 8'hFF, 25'h0000000, 32'h7F800000, 3'b000, 0, 0);
    run_op("lshift23",  1'b1, 8'h90, 25'h0000001, 32'hBC800000, 3'b000, 25, 2);
    run_op("exp0_norm", 1'b0, 8'h00, 25'h0800001, 32'h00000001, 3'b000, 2, 0);

    // Reset during the second left shift of the shift-by-3 operand.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b0;
    bus.in_exp   = 8'h82;
    bus.in_man   = 25'h0180000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_output", 64'(seen), 64'd0);
    chk("midrst_in_ready_after", 64'(bus.in_ready), 64'd1);

    run_op("post_rst_norm", 1'b0, 8'h80, 25'h0C00000, 32'h40400000, 3'b000, 2, 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit reached");
  end

endmodule
